// File: rtl/vmem_pkg.sv
// Shared types and default configuration for the interleaved vector memory controller.
package vmem_pkg;

  localparam int unsigned LanesDefault = 16;
  localparam int unsigned ElemWDefault = 16;
  localparam int unsigned WordWDefault = 32;
  localparam int unsigned AddrWDefault = 13;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StResp
  } state_e;

  typedef logic [WordWDefault-1:0] lane_word_t;

endpackage

// File: rtl/vmem_bank.sv
// Single-port synchronous RAM bank with one-cycle read latency. Contents are not reset.
module vmem_bank
  import vmem_pkg::*;
#(
  parameter int unsigned ELEM_W = ElemWDefault,
  parameter int unsigned ROW_W  = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  addr,
  input  logic [ELEM_W-1:0] wdata,
  output logic [ELEM_W-1:0] rdata
);

  logic [ELEM_W-1:0] mem [2**ROW_W];

  // Write on enable+we, otherwise capture the addressed row for next cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/vmem_ctrl.sv
// Interleaved vector memory controller: LANES banks, rotation crossbar for unaligned access.
// Optional macro VMEM_SIGN_EXT_EN: sign-extend read elements to WORD_W (default zero-extend).
module vmem_ctrl
  import vmem_pkg::*;
#(
  parameter int unsigned LANES  = LanesDefault,
  parameter int unsigned ELEM_W = ElemWDefault,
  parameter int unsigned WORD_W = WordWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic                          vec_scalar,
  input  logic [ADDR_W-1:0]             address,
  input  logic [LANES-1:0]              wr_mask,
  input  logic [LANES-1:0][WORD_W-1:0]  data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [LANES-1:0][WORD_W-1:0]  q
);

  localparam int unsigned LogL = $clog2(LANES);
  localparam int unsigned RowW = ADDR_W - LogL;

  state_e                        state;
  logic [LogL-1:0]               base_q;
  logic                          vec_q;
  logic                          resp_valid_q;
  logic [LANES-1:0][WORD_W-1:0]  q_q;
  logic [LANES-1:0][WORD_W-1:0]  rd_lanes;
  logic                          accept;

  logic [LANES-1:0]  bank_en;
  logic [LogL-1:0]   bank_off   [LANES];
  logic [ADDR_W-1:0] bank_elem  [LANES];
  logic [RowW-1:0]   bank_addr  [LANES];
  logic [ELEM_W-1:0] bank_wdata [LANES];
  logic [ELEM_W-1:0] bank_rdata [LANES];
  logic [LogL-1:0]   lane_bank  [LANES];

  // Upper data bits beyond ELEM_W are deliberately dropped.
  logic unused_data;
  assign unused_data = ^data;

  assign req_ready  = (state == StIdle);
  assign accept     = req_valid & req_ready;
  assign resp_valid = resp_valid_q;
  assign q          = q_q;

  function automatic logic [WORD_W-1:0] extend(input logic [ELEM_W-1:0] e);
    logic [WORD_W-1:0] w;
    w = '0;
    w[ELEM_W-1:0] = e;
`ifdef VMEM_SIGN_EXT_EN
    for (int j = ELEM_W; j < WORD_W; j++) w[j] = e[ELEM_W-1];
`endif
    return w;
  endfunction

  // Forward crossbar: bank b serves lane (b - base) mod LANES at that lane's row.
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      bank_off[b]   = LogL'(b) - address[LogL-1:0];
      bank_elem[b]  = address + {{RowW{1'b0}}, bank_off[b]};
      bank_addr[b]  = bank_elem[b][ADDR_W-1:LogL];
      bank_en[b]    = 1'b0;
      bank_wdata[b] = data[LANES-1][ELEM_W-1:0];
      if (vec_scalar) begin
        bank_wdata[b] = data[bank_off[b]][ELEM_W-1:0];
        bank_en[b]    = accept & (~req_we | wr_mask[bank_off[b]]);
      end else begin
        bank_en[b]    = accept & (bank_off[b] == '0);
      end
    end
  end

  // Reverse crossbar: lane i takes bank (base + i) mod LANES; scalar keeps lane 0 only.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_bank[i] = LogL'(i) + base_q;
      rd_lanes[i]  = '0;
      if (vec_q || i == 0) begin
        rd_lanes[i] = extend(bank_rdata[lane_bank[i]]);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gen_bank
    vmem_bank #(
      .ELEM_W (ELEM_W),
      .ROW_W  (RowW)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en[g]),
      .we    (req_we),
      .addr  (bank_addr[g]),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

  // Request/response FSM with registered response valid and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      base_q       <= '0;
      vec_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      q_q          <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            base_q <= address[LogL-1:0];
            vec_q  <= vec_scalar;
            if (req_we) begin
              state        <= StResp;
              resp_valid_q <= 1'b1;
              q_q          <= '0;
            end else begin
              state <= StRd;
            end
          end
        end
        StRd: begin
          state        <= StResp;
          resp_valid_q <= 1'b1;
          q_q          <= rd_lanes;
        end
        StResp: begin
          if (resp_ready) begin
            state        <= StIdle;
            resp_valid_q <= 1'b0;
            q_q          <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
